// File: rtl/collision_monitor.sv
// Counts dino/obstacle overlap pixels over each full VGA frame and raises a
// latched collision request when the per-frame count reaches THRESH.
module collision_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int THRESH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  vgaX,
  input  logic [9:0]  vgaY,
  input  logic        dinoInGrey,
  input  logic        obstInGrey,
  input  logic [1:0]  gameState,
  input  logic        ack,
  output logic        collide,
  output logic [9:0]  hitX,
  output logic [9:0]  hitY,
  output logic [11:0] lastOverlap
);

  // state | meaning
  // IDLE  | game not running; counter and first-hit flag held clear
  // ARM   | running, waiting for a frame start so only whole frames are scored
  // SCAN  | counting overlap pixels of the current frame
  // HIT   | collision requested; waits for ack, ignores gameState
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_HIT  = 2'd3;

  localparam logic [1:0]  GS_RUN   = 2'b10;
  localparam logic [9:0]  H_ACT_L  = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT_L  = 10'(V_ACTIVE);
  localparam logic [9:0]  H_LAST_L = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST_L = 10'(V_TOTAL - 1);
  localparam logic [11:0] THRESH_L = 12'(THRESH);
  localparam logic [11:0] CNT_MAX  = 12'hFFF;

  logic [1:0]  state;
  logic [11:0] cnt;
  logic        first_seen;

  logic running;
  logic overlap;
  logic frame_start;
  logic frame_end;
  logic [11:0] cnt_inc;

  assign running     = (gameState == GS_RUN);
  assign overlap     = (vgaX < H_ACT_L) && (vgaY < V_ACT_L) && dinoInGrey && obstInGrey;
  assign frame_start = (vgaX == 10'd0) && (vgaY == 10'd0);
  assign frame_end   = (vgaX == H_LAST_L) && (vgaY == V_LAST_L);
  assign cnt_inc     = (cnt == CNT_MAX) ? CNT_MAX : cnt + 12'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 12'd0;
      first_seen  <= 1'b0;
      collide     <= 1'b0;
      hitX        <= 10'd0;
      hitY        <= 10'd0;
      lastOverlap <= 12'd0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt        <= 12'd0;
          first_seen <= 1'b0;
          if (running) state <= S_ARM;
        end
        S_ARM: begin
          if (!running) begin
            state <= S_IDLE;
          end else if (frame_start) begin
            state      <= S_SCAN;
            cnt        <= overlap ? 12'd1 : 12'd0;
            first_seen <= overlap;
            if (overlap) begin
              hitX <= vgaX;
              hitY <= vgaY;
            end
          end
        end
        S_SCAN: begin
          // Leaving the running state drops the partial frame without scoring it.
          if (!running) begin
            state      <= S_IDLE;
            cnt        <= 12'd0;
            first_seen <= 1'b0;
          end else if (frame_end) begin
            lastOverlap <= cnt;
            cnt         <= 12'd0;
            first_seen  <= 1'b0;
            if (cnt >= THRESH_L) begin
              state   <= S_HIT;
              collide <= 1'b1;
            end
          end else if (overlap) begin
            cnt <= cnt_inc;
            if (!first_seen) begin
              hitX       <= vgaX;
              hitY       <= vgaY;
              first_seen <= 1'b1;
            end
          end
        end
        S_HIT: begin
          if (ack) begin
            collide <= 1'b0;
            state   <= running ? S_ARM : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_monitor.sv
// Scoreboard bench for collision_monitor on a shrunken raster (66x65 total,
// 64x64 active) so saturation at 4095 is reachable in one frame.
module tb_collision_monitor;
  localparam int HA = 64;
  localparam int VA = 64;
  localparam int HT = 66;
  localparam int VT = 65;
  localparam int FRAME = HT * VT;

  localparam int P_NONE  = 0;
  localparam int P_THREE = 1;
  localparam int P_FOUR  = 2;
  localparam int P_SIX   = 3;
  localparam int P_TEN   = 4;
  localparam int P_BLANK = 5;
  localparam int P_FULL  = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  vgaX = '0;
  logic [9:0]  vgaY = '0;
  logic        dinoInGrey = 1'b0;
  logic        obstInGrey = 1'b0;
  logic [1:0]  gameState = 2'b10;
  logic        ack = 1'b0;
  logic        collide;
  logic [9:0]  hitX;
  logic [9:0]  hitY;
  logic [11:0] lastOverlap;

  collision_monitor #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT), .THRESH(4)
  ) dut (
    .clk(clk), .rst(rst), .vgaX(vgaX), .vgaY(vgaY),
    .dinoInGrey(dinoInGrey), .obstInGrey(obstInGrey),
    .gameState(gameState), .ack(ack),
    .collide(collide), .hitX(hitX), .hitY(hitY), .lastOverlap(lastOverlap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        col;
    logic [11:0] lo;
    bit          chk_hit;
    logic [9:0]  hx;
    logic [9:0]  hy;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  int rx = 0;
  int ry = 0;
  int pat = P_FULL;
  logic [1:0] gs = 2'b10;
  logic ack_v = 1'b0;

  // Monitor: compares each expectation at the falling edge of its target cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (e.cyc < cyc) begin
        bad++;
        $display("FAIL %s missed: sampled at cycle %0d want cycle %0d", e.tag, cyc, e.cyc);
      end else begin
        if (collide !== e.col) begin
          bad++;
          $display("FAIL %s collide got %0b want %0b", e.tag, collide, e.col);
        end
        total++;
        if (lastOverlap !== e.lo) begin
          bad++;
          $display("FAIL %s lastOverlap got %0d want %0d", e.tag, lastOverlap, e.lo);
        end
        if (e.chk_hit) begin
          total++;
          if (hitX !== e.hx || hitY !== e.hy) begin
            bad++;
            $display("FAIL %s hit got (%0d,%0d) want (%0d,%0d)", e.tag, hitX, hitY, e.hx, e.hy);
          end
        end
      end
    end
  end

  function automatic logic [1:0] flags(int p, int x, int y);
    logic d, o;
    d = 1'b0;
    o = 1'b0;
    case (p)
      P_THREE: begin
        d = (y == 20) && (x >= 10) && (x <= 15);
        o = ((y == 20) && (x >= 8) && (x <= 12)) || (y == 30);
      end
      P_FOUR:  begin d = (y == 0) && (x <= 3); o = d; end
      P_SIX:   begin d = (y == 40) && (x >= 32) && (x <= 37); o = d; end
      P_TEN:   begin d = ((y == 5) || (y == 40)) && (x <= 9); o = d; end
      P_BLANK: begin d = (x >= HA) || (y >= VA); o = d; end
      P_FULL:  begin d = (x < HA) && (y < VA); o = d; end
      default: begin d = 1'b0; o = 1'b0; end
    endcase
    return {d, o};
  endfunction

  task automatic drive_px();
    logic [1:0] f;
    f = flags(pat, rx, ry);
    vgaX = 10'(rx);
    vgaY = 10'(ry);
    dinoInGrey = f[1];
    obstInGrey = f[0];
    gameState = gs;
    ack = ack_v;
  endtask

  task automatic step();
    drive_px();
    @(posedge clk);
    #1;
    if (rx == HT - 1) begin
      rx = 0;
      ry = (ry == VT - 1) ? 0 : ry + 1;
    end else begin
      rx = rx + 1;
    end
  endtask

  task automatic push(int c, logic col, logic [11:0] lo, bit ch, int hx, int hy, string tag);
    exp_t e;
    e.cyc = c; e.col = col; e.lo = lo; e.chk_hit = ch;
    e.hx = 10'(hx); e.hy = 10'(hy); e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic goto_px(int x, int y);
    int n;
    n = 0;
    while (!(rx == x && ry == y)) begin
      step();
      n++;
      if (n > 2 * FRAME) begin
        total++;
        bad++;
        $display("FAIL goto_timeout at (%0d,%0d) want (%0d,%0d)", rx, ry, x, y);
        break;
      end
    end
  endtask

  // Runs through the frame-end pixel and expects the outputs right after that edge.
  task automatic frame_end(logic col, logic [11:0] lo, bit ch, int hx, int hy, string tag);
    goto_px(HT - 1, VT - 1);
    push(cyc + 1, col, lo, ch, hx, hy, tag);
    step();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held mid-frame with gameState running and overlaps present.
    rst = 1'b1; gs = 2'b10; pat = P_FULL;
    repeat (10) step();
    push(cyc, 1'b0, 12'd0, 1'b1, 0, 0, "reset_hold");
    repeat (200) step();
    rst = 1'b0;
    frame_end(1'b0, 12'd0, 1'b1, 0, 0, "arm_partial");

    pat = P_THREE;
    frame_end(1'b0, 12'd3, 1'b1, 10, 20, "below1");
    frame_end(1'b0, 12'd3, 1'b1, 10, 20, "below2");

    pat = P_FOUR;
    frame_end(1'b1, 12'd4, 1'b1, 0, 0, "thresh_eq");

    goto_px(5, 5);
    gs = 2'b00;
    frame_end(1'b1, 12'd4, 1'b1, 0, 0, "hit_hold_gs00");

    goto_px(10, 10);
    ack_v = 1'b1;
    push(cyc, 1'b1, 12'd4, 1'b0, 0, 0, "pre_ack_idle");
    push(cyc + 1, 1'b0, 12'd4, 1'b0, 0, 0, "ack_idle");
    step();
    ack_v = 1'b0;
    goto_px(20, 20);
    gs = 2'b10;
    frame_end(1'b0, 12'd4, 1'b0, 0, 0, "after_ack_idle");

    pat = P_THREE;
    goto_px(11, 20);
    ack_v = 1'b1;
    step();
    ack_v = 1'b0;
    goto_px(30, 30);
    ack_v = 1'b1;
    step();
    ack_v = 1'b0;
    frame_end(1'b0, 12'd3, 1'b1, 10, 20, "stray_ack");

    pat = P_TEN;
    goto_px(20, 5);
    gs = 2'b01;
    goto_px(30, 10);
    gs = 2'b10;
    frame_end(1'b0, 12'd3, 1'b0, 0, 0, "pause_abort");

    pat = P_BLANK;
    frame_end(1'b0, 12'd0, 1'b0, 0, 0, "blank_only");

    pat = P_FULL;
    frame_end(1'b1, 12'd4095, 1'b1, 0, 0, "saturate");

    goto_px(3, 3);
    rst = 1'b1;
    push(cyc, 1'b0, 12'd0, 1'b1, 0, 0, "reset_in_hit");
    pat = P_SIX;
    step();
    step();
    rst = 1'b0;
    frame_end(1'b0, 12'd0, 1'b1, 0, 0, "post_reset_arm");
    frame_end(1'b1, 12'd6, 1'b1, 32, 40, "collide6");

    pat = P_FOUR;
    for (int i = 0; i < 3; i++) frame_end(1'b1, 12'd6, 1'b1, 32, 40, $sformatf("hold%0d", i));

    goto_px(10, 10);
    ack_v = 1'b1;
    push(cyc, 1'b1, 12'd6, 1'b1, 32, 40, "pre_ack_run");
    push(cyc + 1, 1'b0, 12'd6, 1'b1, 32, 40, "ack_run");
    step();
    ack_v = 1'b0;
    frame_end(1'b0, 12'd6, 1'b1, 32, 40, "rearm_partial");
    frame_end(1'b1, 12'd4, 1'b1, 0, 0, "arm_capture");

    step();
    step();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
